// File: rtl/ifetch.sv
// Instruction fetch stage with a byte-serial program loader and an IDLE/RUN/HALTED
// control FSM. Memory is flop-based and can be cleared in a single cycle.
module ifetch #(
  parameter int PC_SIZE   = 32,
  parameter int WORD_SIZE = 32,
  parameter int MEM_WORDS = 64,
  parameter logic [WORD_SIZE-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_stall,
  input  logic                 i_start,
  input  logic                 i_clear_mem,
  input  logic                 i_wr_enable,
  input  logic [7:0]           i_wr_byte,
  input  logic                 i_next_pc_src,
  input  logic [PC_SIZE-1:0]   i_next_not_seq_pc,
  output logic [WORD_SIZE-1:0] o_instruction,
  output logic [PC_SIZE-1:0]   o_next_seq_pc,
  output logic                 o_halt,
  output logic                 o_mem_full,
  output logic                 o_mem_empty
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int PW    = AW + 3;
  localparam int BYTES = MEM_WORDS * 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t               state;
  logic [PC_SIZE-1:0]   pc;
  logic [PW-1:0]        wr_ptr;
  logic                 halt_q;
  logic [WORD_SIZE-1:0] mem [MEM_WORDS];

  logic [AW-1:0]        fetch_addr;
  logic [WORD_SIZE-1:0] fetch_word;
  logic                 advance;

  assign o_mem_full    = (wr_ptr == PW'(BYTES));
  assign o_mem_empty   = (wr_ptr == '0);
  assign fetch_addr    = pc[AW+1:2];
  assign fetch_word    = mem[fetch_addr];
  assign o_instruction = (state == RUN) ? fetch_word : '0;
  assign o_next_seq_pc = pc + PC_SIZE'(4);
  assign o_halt        = halt_q;
  assign advance       = (state == RUN) && i_enable && !i_stall;

  // Clear behaves exactly like reset but is synchronous and wins over every other request.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      pc     <= '0;
      wr_ptr <= '0;
      halt_q <= 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (i_clear_mem) begin
      state  <= IDLE;
      pc     <= '0;
      wr_ptr <= '0;
      halt_q <= 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_wr_enable && !o_mem_full) begin
            mem[wr_ptr[PW-2:2]][{wr_ptr[1:0], 3'b000} +: 8] <= i_wr_byte;
            wr_ptr <= wr_ptr + PW'(1);
          end
          if (i_start && !o_mem_empty) state <= RUN;
        end
        RUN: begin
          if (advance) begin
            if (o_instruction == HALT_WORD) begin
              state  <= HALTED;
              halt_q <= 1'b1;
            end else begin
              pc <= i_next_pc_src ? i_next_not_seq_pc : o_next_seq_pc;
            end
          end
        end
        default: begin
          state  <= HALTED;
          halt_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32: PC and address width.
REQ-002 SHALL have parameter WORD_SIZE, default 32: instruction width.
REQ-003 SHALL have parameter MEM_WORDS, default 64: instruction memory depth, power of two, >=2.
REQ-004 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF: halt instruction encoding.
REQ-005 SHALL have port i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port i_reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_enable  in  1  step/run enable; PC advances only when high.
REQ-008 SHALL have port i_stall  in  1  hazard stall; holds PC.
REQ-009 SHALL have port i_start  in  1  IDLE->RUN request.
REQ-010 SHALL have port i_clear_mem  in  1  clear program; return to IDLE.
REQ-011 SHALL have port i_wr_enable  in  1  loader byte strobe.
REQ-012 SHALL have port i_wr_byte  in  8  loader byte data.
REQ-013 SHALL have port i_next_pc_src  in  1  1 = take i_next_not_seq_pc.
REQ-014 SHALL have port i_next_not_seq_pc  in  PC_SIZE  branch/jump target.
REQ-015 SHALL have port o_instruction  out  WORD_SIZE  fetched instruction.
REQ-016 SHALL have port o_next_seq_pc  out  PC_SIZE  PC + 4.
REQ-017 SHALL have port o_halt  out  1  high in HALTED.
REQ-018 SHALL have port o_mem_full  out  1  loader pointer at capacity.
REQ-019 SHALL have port o_mem_empty  out  1  no bytes loaded.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, HALTED.
REQ-021 SHALL hold memory as MEM_WORDS registered words and a byte pointer wr_ptr of width log2(MEM_WORDS*4)+1.
REQ-022 In IDLE, each i_wr_enable cycle with wr_ptr < MEM_WORDS*4 SHALL write i_wr_byte into word wr_ptr[..:2], bits [8*wr_ptr[1:0]+7 : 8*wr_ptr[1:0]] (little-endian), then increment wr_ptr.
REQ-023 Writes while full, or in RUN/HALTED, SHALL be ignored with no state change.
REQ-024 o_mem_full SHALL equal (wr_ptr == MEM_WORDS*4); o_mem_empty SHALL equal (wr_ptr == 0); both combinational from wr_ptr.
REQ-025 IDLE->RUN SHALL occur on i_start when o_mem_empty is 0 (pre-edge value); i_start is otherwise ignored.
REQ-026 Fetch address SHALL be pc[log2(MEM_WORDS)+1 : 2]; pc[1:0] and upper bits ignored (wrap modulo MEM_WORDS*4 bytes).
REQ-027 In RUN, o_instruction SHALL be memory[fetch address] combinationally; in IDLE and HALTED it SHALL be 0 (NOP).
REQ-028 o_next_seq_pc SHALL be pc + 4, combinational, truncated to PC_SIZE (wraps).
REQ-029 In RUN with i_enable=1, i_stall=0, and o_instruction != HALT_WORD, pc SHALL load i_next_not_seq_pc if i_next_pc_src else pc + 4.
REQ-030 In RUN with i_enable=1, i_stall=0, and o_instruction == HALT_WORD, the FSM SHALL enter HALTED and pc SHALL hold.
REQ-031 i_stall=1 or i_enable=0 SHALL hold pc and state; halt detection occurs only on an advancing cycle.
REQ-032 HALTED SHALL persist until i_clear_mem or reset; i_start is ignored in HALTED.
REQ-033 i_clear_mem in any state SHALL set pc=0, wr_ptr=0, all words=0, state=IDLE; it has priority over i_wr_enable, i_start and PC update in the same cycle.
REQ-034 o_halt SHALL be 1 exactly when the state is HALTED, registered.

Reset
REQ-035 i_reset high SHALL immediately force state=IDLE, pc=0, wr_ptr=0, all words=0, regardless of the clock.
REQ-036 Outputs during and after reset SHALL be o_instruction=0, o_next_seq_pc=4, o_halt=0, o_mem_full=0, o_mem_empty=1.
REQ-037 Reset asserted mid-load or mid-run SHALL discard all loaded content.

Verification
REQ-038 The bench SHALL load bytes 13,00,01,20 then 5 cycles of i_start -> RUN; o_instruction=32'h20010013; with i_enable=1 pc steps 0->4; o_instruction at pc=4 is 0.
REQ-039 The bench SHALL load word0=NOP, word1=FFFFFFFF, then run with i_enable=1 -> pc=4 after edge 1; HALTED and o_halt=1 after edge 2; pc stays 4 and o_instruction=0.
REQ-040 The bench SHALL drive i_next_pc_src=1, i_next_not_seq_pc=0x10 with i_stall=1 -> pc unchanged; after i_stall drops -> pc=0x10.
REQ-041 The bench SHALL write MEM_WORDS*4+3 bytes -> o_mem_full=1 after MEM_WORDS*4 writes; the extra bytes leave memory unchanged.
REQ-042 The bench SHALL assert i_clear_mem together with i_wr_enable and i_start -> IDLE, o_mem_empty=1, word0=0.
REQ-043 The bench SHALL pulse i_reset between clock edges while in RUN at pc=8 -> pc=0, IDLE, o_instruction=0 before the next edge.
